// File: rtl/gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : gpu_cmd_scheduler
// Brief  : Command FIFO that issues GPU commands one at a time and watches each with a timeout
// Rev    : 1.0
// ============================================================================
module gpu_cmd_scheduler #(
    parameter int DEPTH   = 4,
    parameter int OPW     = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [4:0]               cmd_opcode,
    input  logic [OPW-1:0]           cmd_operand,
    input  logic                     flush,
    output logic                     issue_valid,
    output logic [4:0]               issue_opcode,
    output logic [OPW-1:0]           issue_operand,
    input  logic                     core_done,
    output logic                     sched_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              retired_count,
    output logic                     err_illegal,
    output logic                     err_timeout,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_ISSUE = 2'd1;
    localparam logic [1:0]    c_WAIT  = 2'd2;
    localparam logic [LW-1:0] c_FULL  = LW'(DEPTH);
    localparam logic [TW-1:0] c_TMAX  = TW'(TIMEOUT - 1);
    localparam logic [4:0]    c_NXI   = 5'd0;
    localparam logic [4:0]    c_MAXOP = 5'd14;

    logic [4+OPW:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [LW-1:0]   r_level;
    logic [1:0]      r_state;
    logic [TW-1:0]   r_timer;
    logic [4:0]      r_issueOp;
    logic [OPW-1:0]  r_issueOperand;
    logic [15:0]     r_retired;
    logic            r_errIllegal;
    logic            r_errTimeout;

    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_headOp;
    logic [OPW-1:0]  w_headOperand;
    logic            w_popNop;
    logic            w_popIllegal;
    logic            w_doneRetire;
    logic            w_timeout;

    // flush suppresses every side effect of its own cycle except the sticky flags it keeps
    assign w_push       = cmd_valid && cmd_ready && !flush;
    assign w_pop        = (r_state == c_IDLE) && (r_level != '0) && !flush;
    assign {w_headOp, w_headOperand} = r_mem[r_rdPtr];
    assign w_popNop     = w_pop && (w_headOp == c_NXI);
    assign w_popIllegal = w_pop && (w_headOp > c_MAXOP);
    assign w_doneRetire = (r_state == c_WAIT) && core_done && !flush;
    assign w_timeout    = (r_state == c_WAIT) && !core_done && (r_timer == c_TMAX) && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {cmd_opcode, cmd_operand};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_timer        <= '0;
            r_issueOp      <= '0;
            r_issueOperand <= '0;
        end else if (flush) begin
            r_state <= c_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop && !w_popNop && !w_popIllegal) begin
                        r_issueOp      <= w_headOp;
                        r_issueOperand <= w_headOperand;
                        r_state        <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_timer <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_doneRetire || w_timeout) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // A new error in the same cycle as err_clr leaves the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired    <= '0;
            r_errIllegal <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            if (w_popNop || w_doneRetire) r_retired <= r_retired + 16'd1;
            r_errIllegal <= (r_errIllegal && !err_clr) || w_popIllegal;
            r_errTimeout <= (r_errTimeout && !err_clr) || w_timeout;
        end
    end

    assign cmd_ready     = r_level < c_FULL;
    assign issue_valid   = (r_state == c_ISSUE);
    assign issue_opcode  = r_issueOp;
    assign issue_operand = r_issueOperand;
    assign sched_busy    = (r_state != c_IDLE) || (r_level != '0);
    assign fifo_level    = r_level;
    assign retired_count = r_retired;
    assign err_illegal   = r_errIllegal;
    assign err_timeout   = r_errTimeout;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_gpu_cmd_scheduler
// Brief  : Directed self-checking bench for gpu_cmd_scheduler (DEPTH=4, TIMEOUT=8)
// Rev    : 1.0
// ============================================================================
module tb_gpu_cmd_scheduler;

    localparam int DEPTH   = 4;
    localparam int OPW     = 16;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [4:0]             cmd_opcode;
    logic [OPW-1:0]         cmd_operand;
    logic                   flush;
    logic                   issue_valid;
    logic [4:0]             issue_opcode;
    logic [OPW-1:0]         issue_operand;
    logic                   core_done;
    logic                   sched_busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            retired_count;
    logic                   err_illegal;
    logic                   err_timeout;
    logic                   err_clr;

    int total = 0;
    int bad   = 0;

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_operand   (cmd_operand),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_opcode  (issue_opcode),
        .issue_operand (issue_operand),
        .core_done     (core_done),
        .sched_busy    (sched_busy),
        .fifo_level    (fifo_level),
        .retired_count (retired_count),
        .err_illegal   (err_illegal),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] op, input logic [OPW-1:0] operand);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_operand = operand;
        step(1);
        cmd_valid   = 1'b0;
    endtask

    // In-flight command is acknowledged the cycle after ISSUE
    task automatic finish_cmd();
        step(1);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
    endtask

    logic [4:0]     expOp  [4];
    logic [OPW-1:0] expOpd [4];

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_operand = '0;
        flush = 1'b0; core_done = 1'b0; err_clr = 1'b0;
        step(2);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_cmd_ready",   32'(cmd_ready), 1);
        chk("rst_level",       32'(fifo_level), 0);
        chk("rst_retired",     32'(retired_count), 0);
        chk("rst_busy",        32'(sched_busy), 0);
        chk("rst_errs",        32'({err_illegal, err_timeout}), 0);
        chk("rst_issue_op",    32'({issue_opcode, issue_operand}), 0);
        reset = 1'b0;
        step(1);

        // Single LDC: issue two cycles after the push
        push(5'd2, 16'h1234);
        chk("t1_level",   32'(fifo_level), 1);
        chk("t1_busy",    32'(sched_busy), 1);
        chk("t1_novalid", 32'(issue_valid), 0);
        step(1);
        chk("t1_valid",   32'(issue_valid), 1);
        chk("t1_opcode",  32'(issue_opcode), 2);
        chk("t1_operand", 32'(issue_operand), 32'h1234);
        step(1);
        chk("t1_strobe_end", 32'(issue_valid), 0);
        chk("t1_hold",       32'(issue_operand), 32'h1234);
        step(4);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        chk("t1_retired", 32'(retired_count), 1);
        chk("t1_idle",    32'(sched_busy), 0);

        // Fill the FIFO behind a blocking command
        expOp[0] = 5'd1;  expOpd[0] = 16'h0001;
        expOp[1] = 5'd6;  expOpd[1] = 16'h0002;
        expOp[2] = 5'd8;  expOpd[2] = 16'h0003;
        expOp[3] = 5'd14; expOpd[3] = 16'h0004;
        push(5'd3, 16'hAAAA);
        for (int i = 0; i < 4; i++) push(expOp[i], expOpd[i]);
        chk("t2_full_level", 32'(fifo_level), 4);
        chk("t2_not_ready",  32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_opcode = 5'd9; cmd_operand = 16'hEEEE;
        step(1);
        cmd_valid = 1'b0;
        chk("t2_held_level", 32'(fifo_level), 4);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        chk("t2_blk_retired", 32'(retired_count), 2);
        step(1);
        chk("t2_level_after", 32'(fifo_level), 3);
        chk("t2_ready_back",  32'(cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_valid%0d", i),   32'(issue_valid), 1);
            chk($sformatf("t2_opcode%0d", i),  32'(issue_opcode), 32'(expOp[i]));
            chk($sformatf("t2_operand%0d", i), 32'(issue_operand), 32'(expOpd[i]));
            finish_cmd();
            step(1);
        end
        chk("t2_retired", 32'(retired_count), 6);
        chk("t2_empty",   32'(fifo_level), 0);
        chk("t2_idle",    32'(sched_busy), 0);

        // Two no-ops drain ahead of MM2
        push(5'd0, 16'h0000);
        push(5'd0, 16'h0000);
        push(5'd5, 16'hBEEF);
        chk("t3_no_issue_yet", 32'(issue_valid), 0);
        chk("t3_nxi_retired",  32'(retired_count), 8);
        step(1);
        chk("t3_valid",   32'(issue_valid), 1);
        chk("t3_opcode",  32'(issue_opcode), 5);
        chk("t3_operand", 32'(issue_operand), 32'hBEEF);
        finish_cmd();
        chk("t3_retired", 32'(retired_count), 9);

        // Illegal opcode is dropped and flagged
        push(5'd31, 16'h0F0F);
        push(5'd10, 16'h00AA);
        chk("t4_err_illegal", 32'(err_illegal), 1);
        chk("t4_not_retired", 32'(retired_count), 9);
        step(1);
        chk("t4_valid",  32'(issue_valid), 1);
        chk("t4_opcode", 32'(issue_opcode), 10);
        finish_cmd();
        chk("t4_retired", 32'(retired_count), 10);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_cleared", 32'(err_illegal), 0);
        push(5'd15, 16'h0000);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_set_wins", 32'(err_illegal), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_cleared2", 32'(err_illegal), 0);

        // Timeout after exactly TIMEOUT cycles in WAIT
        push(5'd7, 16'h7777);
        push(5'd2, 16'h5555);
        chk("t5_valid",  32'(issue_valid), 1);
        chk("t5_opcode", 32'(issue_opcode), 7);
        step(8);
        chk("t5_no_timeout_yet", 32'(err_timeout), 0);
        chk("t5_busy",           32'(sched_busy), 1);
        step(1);
        chk("t5_err_timeout", 32'(err_timeout), 1);
        chk("t5_level",       32'(fifo_level), 1);
        step(1);
        chk("t5_next_valid",   32'(issue_valid), 1);
        chk("t5_next_opcode",  32'(issue_opcode), 2);
        chk("t5_next_operand", 32'(issue_operand), 32'h5555);
        chk("t5_no_retire",    32'(retired_count), 10);
        finish_cmd();
        chk("t5_retired", 32'(retired_count), 11);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t5_cleared", 32'(err_timeout), 0);

        // Flush in WAIT with three queued and a simultaneous push
        push(5'd4, 16'h1111);
        push(5'd1, 16'h2222);
        push(5'd3, 16'h3333);
        push(5'd6, 16'h4444);
        chk("t6_level", 32'(fifo_level), 3);
        flush = 1'b1; cmd_valid = 1'b1; cmd_opcode = 5'd9; cmd_operand = 16'h5A5A;
        step(1);
        flush = 1'b0; cmd_valid = 1'b0;
        chk("t6_empty", 32'(fifo_level), 0);
        chk("t6_idle",  32'(sched_busy), 0);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        chk("t6_retired_kept", 32'(retired_count), 11);
        chk("t6_still_idle",   32'(sched_busy), 0);

        // Asynchronous reset during WAIT wins over a coincident done
        push(5'd2, 16'h9999);
        step(2);
        core_done = 1'b1;
        reset = 1'b1;
        #1;
        chk("t7_async_retired", 32'(retired_count), 0);
        chk("t7_async_busy",    32'(sched_busy), 0);
        chk("t7_async_operand", 32'(issue_operand), 0);
        step(1);
        core_done = 1'b0;
        reset = 1'b0;
        step(1);
        chk("t7_retired", 32'(retired_count), 0);
        chk("t7_ready",   32'(cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
